// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master drives requests and sinks encoded words; the slave is the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words, range-checks immediates and
// streams legal words to auto-incrementing byte addresses through a one-entry stage.
module instr_encoder #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    instr_encoder_if.slave     bus,
    output logic               err,
    output logic [7:0]         err_cnt
);
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ISH = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    localparam int unsigned WORD_W = 32;

    logic [WORD_W-1:0] imm;
    logic [6:0]        op;
    logic [WORD_W-1:0] enc;
    logic              legal;
    logic              accept;

    logic              valid_q;
    logic [WORD_W-1:0] instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] next_addr_q;

    assign imm    = bus.in_imm;
    assign op     = bus.in_opcode;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !clr && (!valid_q || bus.out_ready);
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;

    // Field packing and immediate range check per format
    always_comb begin
        enc   = '0;
        legal = 1'b0;
        case (fmt_e'(bus.in_fmt))
            FMT_R: begin
                enc   = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, op};
                legal = 1'b1;
            end
            FMT_I: begin
                enc   = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};
                legal = (imm == {{20{imm[11]}}, imm[11:0]});
            end
            FMT_S: begin
                enc   = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], op};
                legal = (imm == {{20{imm[11]}}, imm[11:0]});
            end
            FMT_B: begin
                enc   = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         imm[4:1], imm[11], op};
                legal = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
            end
            FMT_U: begin
                enc   = {imm[31:12], bus.in_rd, op};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                enc   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
                legal = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];
            end
            FMT_ISH: begin
                enc   = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};
                legal = (imm[31:5] == 27'd0);
            end
            FMT_RSV: begin
                enc   = '0;
                legal = 1'b0;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Output stage, address counter and error tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q     <= 1'b0;
            instr_q     <= '0;
            addr_q      <= BASE_ADDR;
            next_addr_q <= BASE_ADDR;
            err         <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            if (accept && legal) begin
                valid_q     <= 1'b1;
                instr_q     <= enc;
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + ADDR_W'(4);
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            // clr never coincides with an accept because in_ready is held low
            if (clr) begin
                next_addr_q <= BASE_ADDR;
                err         <= 1'b0;
                err_cnt     <= 8'd0;
            end else if (accept && !legal) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate-extraction decode path: packs opcode, register, funct and immediate fields into a 32-bit RV32I instruction word.
- Range-checks the immediate against its format and streams accepted words to the instruction-memory write port at auto-incrementing addresses.
- Used by the boot/self-test loader and by the decode-path verification harness.
- One-entry registered output stage; ready/valid on both sides.

Parameters:
- ADDR_W, 16, width of out_addr (byte address).
- BASE_ADDR, 0, address of the first word after reset or clr.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear: address back to BASE_ADDR, error state cleared.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift, 7=reserved.
- in_opcode  in  7  instr[6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R and I-shift formats).
- in_imm  in  32  signed immediate (byte offset for B and J).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- err  out  1  sticky range-error flag.
- err_cnt  out  8  saturating count of rejected requests.

Behaviour:
- Reset (resetn low, async):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_cnt=0.
  - The internal next-address counter is set to BASE_ADDR.
  - Any pending output is discarded.
- in_ready = !clr && (!out_valid || out_ready). The stage is a full-throughput pipeline, one word per cycle.
- Latency: a request accepted in cycle N presents on out_* in cycle N+1.
- While out_valid=1 && out_ready=0, out_instr and out_addr hold stable.
- Encoding (instr[6:0]=in_opcode throughout):
  - R: funct7 | rs2 | rs1 | funct3 | rd.
  - I: imm[11:0] | rs1 | funct3 | rd.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U: imm[31:12] | rd.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
  - I-shift: funct7 | imm[4:0] | rs1 | funct3 | rd.
- Range legality:
  - I and S: in_imm equals the sign-extension of in_imm[11:0].
  - B: equals the sign-extension of in_imm[12:0], and in_imm[0]=0.
  - J: equals the sign-extension of in_imm[20:0], and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - I-shift: in_imm[31:5]=0.
  - R: in_imm ignored.
  - fmt 7: always illegal.
- Illegal request:
  - Consumed (handshake completes); no output is produced and the address does not advance.
  - err<=1; err_cnt increments, saturating at 255.
  - out_valid follows normal drain rules in the same cycle.
- Address: each legal accepted request takes the current counter value as its out_addr, then the counter advances by 4, wrapping modulo 2^ADDR_W.
- clr:
  - Counter <= BASE_ADDR, err<=0, err_cnt<=0.
  - in_ready forced 0, so no accept collides with clr.
  - An already-held output word stays valid with its original address until drained.
- Reset mid-stream: the pending word is lost and the next accepted word is at BASE_ADDR.

Test Plan:
- Reset, then request I fmt, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> cycle after accept: out_valid=1, out_instr=0x00500093, out_addr=0x0000.
- S fmt, opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8, back-to-back with B fmt, opcode 1100011, rs1=rs2=0, funct3=0, imm=-4 -> 0x0020A423 @0x0000, then 0xFE000EE3 @0x0004, one per cycle.
- J fmt, opcode 1101111, rd=1, imm=2048 -> 0x001000EF. U fmt, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- I fmt imm=2048, then B fmt imm=6 (legal), then B fmt imm=7 (odd offset) -> 2048 and 7 produce no output; err=1, err_cnt=2; the legal B word gets the next address; address advanced only once.
- Hold out_ready=0 for 3 cycles with a word pending -> in_ready=0, out_instr/out_addr stable; on release the word drains and the next request is accepted the same cycle.
- Pulse clr after 3 words, then one more request -> out_addr=BASE_ADDR, err=0. Assert resetn low with out_valid=1 -> out_valid drops immediately (async).
- With ADDR_W=4, issue 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0 (wrap).
